uart_rx_ctrl: RTL

//  Frame controller for the UART receive path. Runs the oversampled bit timing
//  (edge/bit counters) and sequences start check, data shift, parity check and

---
 rtl/uart_rx_pkg.sv | 17 +
 rtl/uart_edge_bit_counter.sv | 34 +++
 rtl/uart_rx_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive frame controller.
package uart_rx_pkg;

  localparam int unsigned UART_DATA_W       = 8;
  localparam int unsigned UART_PRESCALE_W   = 6;
  localparam int unsigned PRESCALE_MIN      = 4;
  localparam int unsigned PRESCALE_FALLBACK = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_edge_bit_counter.sv
// Oversample edge counter and data-bit counter for the UART receive path.
module uart_edge_bit_counter
  import uart_rx_pkg::*;
#(
  parameter int unsigned PRESCALE_W = UART_PRESCALE_W,
  parameter int unsigned BIT_W      = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  clr,
  input  logic                  cnt_bit,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic                  last_edge,
  output logic [BIT_W-1:0]      bit_cnt
);

  assign last_edge = en && (edge_cnt == prescale - PRESCALE_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      if (!en || clr || last_edge) edge_cnt <= '0;
      else                         edge_cnt <= edge_cnt + PRESCALE_W'(1);

      if (!en || clr)   bit_cnt <= '0;
      else if (cnt_bit) bit_cnt <= bit_cnt + BIT_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: sequences start, data, parity and stop bits
// and strobes the deserializer and bit checkers on the last oversample edge.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_W     = UART_DATA_W,
  parameter int unsigned PRESCALE_W = UART_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  PAR_EN,
  input  logic                  strt_glitch,
  input  logic                  par_err,
  input  logic                  stp_err,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic                  dat_samp_en,
  output logic                  new_op_flag,
  output logic                  deser_en,
  output logic                  strt_chk_en,
  output logic                  par_chk_en,
  output logic                  stp_chk_en,
  output logic                  data_valid,
  output logic                  par_err_flag,
  output logic                  frm_err_flag,
  output logic                  busy
);

  localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  rx_state_e             state;
  logic [PRESCALE_W-1:0] p_lat;
  logic                  pe;
  logic                  last_edge;
  logic                  last_bit;
  logic                  state_exit;
  logic [BIT_W-1:0]      bit_cnt;

  assign busy        = (state != IDLE);
  assign dat_samp_en = busy;

  uart_edge_bit_counter #(
    .PRESCALE_W (PRESCALE_W),
    .BIT_W      (BIT_W)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .en        (busy),
    .prescale  (p_lat),
    .clr       (state_exit),
    .cnt_bit   (deser_en),
    .edge_cnt  (edge_cnt),
    .last_edge (last_edge),
    .bit_cnt   (bit_cnt)
  );

  always_comb begin
    strt_chk_en = last_edge && (state == START);
    deser_en    = last_edge && (state == DATA);
    par_chk_en  = last_edge && (state == PARITY);
    stp_chk_en  = last_edge && (state == STOP);
    last_bit    = (bit_cnt == BIT_W'(DATA_W - 1));
    // every state transition out of a busy state happens on a last edge
    state_exit  = strt_chk_en || (deser_en && last_bit) || par_chk_en || stp_chk_en;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      p_lat        <= '0;
      pe           <= 1'b0;
      new_op_flag  <= 1'b0;
      data_valid   <= 1'b0;
      par_err_flag <= 1'b0;
      frm_err_flag <= 1'b0;
    end else begin
      new_op_flag  <= 1'b0;
      data_valid   <= 1'b0;
      par_err_flag <= 1'b0;
      frm_err_flag <= 1'b0;
      case (state)
        IDLE: begin
          if (!RX_IN) begin
            state       <= START;
            pe          <= PAR_EN;
            new_op_flag <= 1'b1;
            if (Prescale < PRESCALE_W'(PRESCALE_MIN)) p_lat <= PRESCALE_W'(PRESCALE_FALLBACK);
            else                                      p_lat <= Prescale;
          end
        end
        START: begin
          if (strt_chk_en) state <= strt_glitch ? IDLE : DATA;
        end
        DATA: begin
          if (deser_en && last_bit) state <= pe ? PARITY : STOP;
        end
        PARITY: begin
          if (par_chk_en) begin
            if (par_err) begin
              state        <= IDLE;
              par_err_flag <= 1'b1;
            end else begin
              state <= STOP;
            end
          end
        end
        STOP: begin
          if (stp_chk_en) begin
            state <= IDLE;
            if (stp_err) frm_err_flag <= 1'b1;
            else         data_valid   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
